a23_init_loader: RTL and testbench

- Upstream feeder for the garbled A23 core (a23_gc_main).
- Accepts a serial 32-bit word stream over a valid/ready handshake and assembles the flat p_init, g_init and e_init vectors the core consumes.
- Holds the core in reset while loading and releases it once all regions are filled.
- Observes the core's terminate and supports a reload/rerun cycle.

---
 rtl/a23_init_loader.sv | 205 ++++++++++++++++++++
 tb/tb_a23_init_loader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/a23_init_loader.sv
// a23_init_loader
//    Feeds the garbled A23 core. A serial stream of 32-bit words arrives over
//    a valid/ready handshake and is unpacked, in order, into the code image
//    (p_init), the garbler inputs (g_init) and the evaluator inputs (e_init).
//    The core is held in reset while loading, released HOLD_CYCLES cycles
//    after the last word, and its terminate flag is captured as a sticky done.
//    A start pulse while running reloads all regions and reruns the core.
//
// Ports
//    clk        system clock, all logic on the rising edge
//    rst        synchronous active-high reset
//    start      one-cycle pulse, begins a load (from IDLE or RUN)
//    in_valid   stream word valid
//    in_ready   loader accepts a word this cycle (registered)
//    in_data    stream word
//    terminate  core terminate flag
//    p_init     code image, word i at [32*i +: 32]
//    g_init     garbler input words, same packing
//    e_init     evaluator input words, same packing
//    core_rst   active-high reset to the core
//    loaded     all regions written and core released
//    done       core terminated since the last release (sticky)
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for start, core held in reset
// LOAD_P | filling code words, in_ready high
// LOAD_G | filling garbler input words, in_ready high
// LOAD_E | filling evaluator input words, in_ready high
// HOLD   | all words loaded, core reset held for HOLD_CYCLES cycles
// RUN    | core released, watching terminate, waiting for reload start

module a23_init_loader #(
    parameter int CODE_MEM_SIZE = 512,
    parameter int G_MEM_SIZE    = 64,
    parameter int E_MEM_SIZE    = 64,
    parameter int HOLD_CYCLES   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_data,
    input  logic                       terminate,
    output logic [CODE_MEM_SIZE*32-1:0] p_init,
    output logic [G_MEM_SIZE*32-1:0]    g_init,
    output logic [E_MEM_SIZE*32-1:0]    e_init,
    output logic                       core_rst,
    output logic                       loaded,
    output logic                       done
);

    localparam int PW  = (CODE_MEM_SIZE > 1) ? $clog2(CODE_MEM_SIZE) : 1;
    localparam int GW  = (G_MEM_SIZE > 1)    ? $clog2(G_MEM_SIZE)    : 1;
    localparam int EW  = (E_MEM_SIZE > 1)    ? $clog2(E_MEM_SIZE)    : 1;
    localparam int PGW = (PW > GW) ? PW : GW;
    localparam int CW  = (PGW > EW) ? PGW : EW;
    localparam int HW  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [CW-1:0] P_LAST    = CW'(CODE_MEM_SIZE - 1);
    localparam logic [CW-1:0] G_LAST    = CW'(G_MEM_SIZE - 1);
    localparam logic [CW-1:0] E_LAST    = CW'(E_MEM_SIZE - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_P,
        LOAD_G,
        LOAD_E,
        HOLD,
        RUN
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [HW-1:0]   hcnt, hcnt_n;
    logic            core_rst_n, loaded_n, done_n, in_ready_n;
    logic            wr_p, wr_g, wr_e;
    logic            accept;

    logic [CODE_MEM_SIZE-1:0][31:0] p_mem;
    logic [G_MEM_SIZE-1:0][31:0]    g_mem;
    logic [E_MEM_SIZE-1:0][31:0]    e_mem;

    assign p_init = p_mem;
    assign g_init = g_mem;
    assign e_init = e_mem;

    assign accept = in_valid && in_ready;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        hcnt_n     = hcnt;
        core_rst_n = core_rst;
        loaded_n   = loaded;
        done_n     = done;
        wr_p       = 1'b0;
        wr_g       = 1'b0;
        wr_e       = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n    = LOAD_P;
                    cnt_n      = '0;
                    core_rst_n = 1'b1;
                end
            end
            LOAD_P: begin
                if (accept) begin
                    wr_p = 1'b1;
                    if (cnt == P_LAST) begin
                        state_n = LOAD_G;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            LOAD_G: begin
                if (accept) begin
                    wr_g = 1'b1;
                    if (cnt == G_LAST) begin
                        state_n = LOAD_E;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            LOAD_E: begin
                if (accept) begin
                    wr_e = 1'b1;
                    if (cnt == E_LAST) begin
                        state_n = HOLD;
                        cnt_n   = '0;
                        hcnt_n  = HOLD_LOAD;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            HOLD: begin
                // terminal count releases the core on the same edge loaded rises
                if (hcnt == '0) begin
                    state_n    = RUN;
                    core_rst_n = 1'b0;
                    loaded_n   = 1'b1;
                end else begin
                    hcnt_n = hcnt - 1'b1;
                end
            end
            RUN: begin
                // reload takes priority over a coincident terminate
                if (start) begin
                    state_n    = LOAD_P;
                    cnt_n      = '0;
                    core_rst_n = 1'b1;
                    loaded_n   = 1'b0;
                    done_n     = 1'b0;
                end else if (terminate) begin
                    done_n = 1'b1;
                end
            end
            default: begin
                state_n    = IDLE;
                cnt_n      = '0;
                core_rst_n = 1'b1;
                loaded_n   = 1'b0;
                done_n     = 1'b0;
            end
        endcase

        in_ready_n = (state_n == LOAD_P) || (state_n == LOAD_G) || (state_n == LOAD_E);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            hcnt     <= '0;
            core_rst <= 1'b1;
            loaded   <= 1'b0;
            done     <= 1'b0;
            in_ready <= 1'b0;
            p_mem    <= '0;
            g_mem    <= '0;
            e_mem    <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            hcnt     <= hcnt_n;
            core_rst <= core_rst_n;
            loaded   <= loaded_n;
            done     <= done_n;
            in_ready <= in_ready_n;
            if (wr_p) p_mem[cnt[PW-1:0]] <= in_data;
            if (wr_g) g_mem[cnt[GW-1:0]] <= in_data;
            if (wr_e) e_mem[cnt[EW-1:0]] <= in_data;
        end
    end

endmodule

// File: tb/tb_a23_init_loader.sv
// tb_a23_init_loader
//    Directed bench for a23_init_loader with a small configuration
//    (4 code words, 2 garbler words, 2 evaluator words, hold of 2 cycles).
//    Each word issued pushes its expected destination and value into a queue;
//    a monitor pops an entry on every accepted word and checks the word landed
//    in the right slot. Release timing, reset state and full vectors are
//    checked directly by the stimulus process.

module tb_a23_init_loader;

    localparam int CODE = 4;
    localparam int G    = 2;
    localparam int E    = 2;
    localparam int HC   = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          in_data;
    logic                 terminate;
    logic [CODE*32-1:0]   p_init;
    logic [G*32-1:0]      g_init;
    logic [E*32-1:0]      e_init;
    logic                 core_rst;
    logic                 loaded;
    logic                 done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          region;
        int          idx;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];

    a23_init_loader #(
        .CODE_MEM_SIZE (CODE),
        .G_MEM_SIZE    (G),
        .E_MEM_SIZE    (E),
        .HOLD_CYCLES   (HC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .terminate (terminate),
        .p_init    (p_init),
        .g_init    (g_init),
        .e_init    (e_init),
        .core_rst  (core_rst),
        .loaded    (loaded),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input int region, input int idx);
        case (region)
            0:       return p_init[idx*32 +: 32];
            1:       return g_init[idx*32 +: 32];
            default: return e_init[idx*32 +: 32];
        endcase
    endfunction

    // scoreboard monitor: one pop per accepted word, slot checked after the edge
    bit   pend = 1'b0;
    exp_t cur;
    always @(negedge clk) begin
        if (pend) begin
            pend = 1'b0;
            check($sformatf("sb_word r%0d i%0d", cur.region, cur.idx),
                  128'(word_at(cur.region, cur.idx)), 128'(cur.data));
        end
        if (!rst && in_valid && in_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: accepted %h expected no accept", in_data);
            end else begin
                cur = q.pop_front();
                check("sb_data", 128'(in_data), 128'(cur.data));
                pend = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_range(input logic [31:0] base, input int first, input int last, input bit stall);
        for (int k = first; k <= last; k++) begin
            exp_t e;
            bit   ok;
            e.data = base + 32'(k);
            if (k < CODE) begin
                e.region = 0; e.idx = k;
            end else if (k < CODE + G) begin
                e.region = 1; e.idx = k - CODE;
            end else begin
                e.region = 2; e.idx = k - CODE - G;
            end
            q.push_back(e);
            if (stall && k != first) begin
                in_valid = 1'b0;
                tick();
            end
            in_valid = 1'b1;
            in_data  = base + 32'(k);
            ok = 1'b0;
            for (int t = 0; t < 20 && !ok; t++) begin
                @(negedge clk);
                if (in_ready) ok = 1'b1;
                tick();
            end
            if (!ok) begin
                total++;
                bad++;
                $display("FAIL accept_timeout: word %0d in_ready=0 expected 1", k);
            end
        end
        in_valid = 1'b0;
    endtask

    // called one cycle after the last E word is accepted
    task automatic check_release(input bit term_in_hold);
        check("ready_drop", 128'(in_ready), 128'(0));
        check("hold0_rst", 128'(core_rst), 128'(1));
        if (term_in_hold) terminate = 1'b1;
        tick();
        terminate = 1'b0;
        check("hold1_rst", 128'({core_rst, loaded}), 128'(2'b10));
        tick();
        check("release", 128'({core_rst, loaded}), 128'(2'b01));
        check("done_clear", 128'(done), 128'(0));
    endtask

    task automatic check_vecs(input logic [31:0] base);
        logic [CODE*32-1:0] pe;
        logic [G*32-1:0]    ge;
        logic [E*32-1:0]    ee;
        for (int i = 0; i < CODE; i++) pe[i*32 +: 32] = base + 32'(i);
        for (int i = 0; i < G; i++)    ge[i*32 +: 32] = base + 32'(CODE + i);
        for (int i = 0; i < E; i++)    ee[i*32 +: 32] = base + 32'(CODE + G + i);
        check("p_init", 128'(p_init), 128'(pe));
        check("g_init", 128'(g_init), 128'(ge));
        check("e_init", 128'(e_init), 128'(ee));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_vec"}, {p_init[63:0], g_init, e_init}, 128'(0));
        check({tag, "_vec_hi"}, 128'(p_init[127:64]), 128'(0));
        check({tag, "_ctl"}, 128'({core_rst, in_ready, loaded, done}), 128'(4'b1000));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; terminate = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_state("reset");

        // idle ignores a stream word without start
        in_valid = 1'b1; in_data = 32'hDEAD;
        tick();
        in_valid = 1'b0;
        check("idle_ready", 128'(in_ready), 128'(0));

        // full load, back-to-back
        pulse_start();
        check("load_entry", 128'({in_ready, core_rst, loaded}), 128'(3'b110));
        send_range(32'h10, 0, 7, 1'b0);
        check_release(1'b0);
        check_vecs(32'h10);

        // terminate then reload
        tick();
        check("run_done0", 128'(done), 128'(0));
        terminate = 1'b1;
        tick();
        terminate = 1'b0;
        check("done_set", 128'(done), 128'(1));
        tick();
        check("done_sticky", 128'(done), 128'(1));
        pulse_start();
        check("reload_ctl", 128'({core_rst, done, loaded, in_ready}), 128'(4'b1001));
        send_range(32'h20, 0, 7, 1'b0);
        check_release(1'b0);
        check_vecs(32'h20);

        // stalled stream (reload over the 0x20 image)
        pulse_start();
        send_range(32'h10, 0, 7, 1'b1);
        check_release(1'b0);
        check_vecs(32'h10);

        // mid-load reset after 5 words (in LOAD_G)
        pulse_start();
        send_range(32'h30, 0, 4, 1'b0);
        check("midload_ready", 128'(in_ready), 128'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_state("midrst");

        // start/valid collision in IDLE, then a normal full load
        start = 1'b1; in_valid = 1'b1; in_data = 32'hAA;
        tick();
        start = 1'b0;
        check("collide_ready", 128'(in_ready), 128'(1));
        send_range(32'h40, 0, 7, 1'b0);
        check_release(1'b0);
        check_vecs(32'h40);

        // ignored events: start during LOAD_E, terminate during HOLD
        pulse_start();
        send_range(32'h60, 0, 5, 1'b0);
        pulse_start();
        check("ign_start", 128'({in_ready, core_rst, loaded}), 128'(3'b110));
        send_range(32'h60, 6, 7, 1'b0);
        check_release(1'b1);
        check_vecs(32'h60);
        tick();
        check("ign_term_done", 128'(done), 128'(0));

        @(negedge clk);
        check("sb_drained", 128'(q.size()), 128'(0));
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
